// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM arbiter: owner encoding, FSM states, bus widths.
package vram_arb_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_PPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

endpackage

// File: rtl/vram_arb_prio.sv
// Combinational fixed-priority picker: PPU > DMA > CPU.
module vram_arb_prio
    import vram_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ppu_req,
    input  logic   dma_req,
    output owner_e pick
);

    always_comb begin
        if (ppu_req)      pick = OWN_PPU;
        else if (dma_req) pick = OWN_DMA;
        else if (cpu_req) pick = OWN_CPU;
        else              pick = OWN_NONE;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Three-requester VRAM arbiter running IDLE->ADDR->DATA pin cycles.
// Optional CPU lockout during pixel transfer: define VRAM_ARBITER_CPU_LOCK_EN.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              ppu_busy,
    output logic              cpu_ack,
    output logic              ppu_ack,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ma,
    output logic [DATA_W-1:0] md_out,
    output logic              md_oe,
    input  logic [DATA_W-1:0] md_in,
    output logic              nmcs,
    output logic              nmoe,
    output logic              nmwr,
    output logic [1:0]        owner
);

    state_e            state, state_nxt;
    owner_e            own_q, pick;
    logic [ADDR_W-1:0] addr_q, grant_addr;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              lock_hit;
    logic              cpu_r, ppu_r, dma_r;

    // A requester may still hold req in its ack cycle; don't re-grant it then.
    assign cpu_r = cpu_req & ~cpu_ack;
    assign ppu_r = ppu_req & ~ppu_ack;
    assign dma_r = dma_req & ~dma_ack;

    vram_arb_prio u_prio (
        .cpu_req (cpu_r),
        .ppu_req (ppu_r),
        .dma_req (dma_r),
        .pick    (pick)
    );

`ifdef VRAM_ARBITER_CPU_LOCK_EN
    assign lock_hit = (state == IDLE) && (pick == OWN_CPU) && ppu_busy;
`else
    logic unused_busy;
    assign unused_busy = ppu_busy;
    assign lock_hit    = 1'b0;
`endif

    always_comb begin
        case (pick)
            OWN_PPU: grant_addr = ppu_addr;
            OWN_DMA: grant_addr = dma_addr;
            default: grant_addr = cpu_addr;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick != OWN_NONE && !lock_hit) state_nxt = ADDR;
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            own_q   <= OWN_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata   <= '1;
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (state == IDLE) begin
                if (lock_hit) begin
                    // Locked-out CPU gets an immediate ack with no memory cycle.
                    cpu_ack <= 1'b1;
                    if (!cpu_wr) rdata <= '1;
                end else if (pick != OWN_NONE) begin
                    own_q   <= pick;
                    addr_q  <= grant_addr;
                    wdata_q <= cpu_wdata;
                    wr_q    <= (pick == OWN_CPU) && cpu_wr;
                end
            end else if (state == DATA) begin
                if (!wr_q) rdata <= md_in;
                cpu_ack <= (own_q == OWN_CPU);
                ppu_ack <= (own_q == OWN_PPU);
                dma_ack <= (own_q == OWN_DMA);
                own_q   <= OWN_NONE;
            end
        end
    end

    always_comb begin
        nmcs   = !(state == ADDR || state == DATA);
        nmoe   = !(state == DATA && !wr_q);
        nmwr   = !(state == DATA && wr_q);
        md_oe  = (state == DATA) && wr_q;
        md_out = md_oe ? wdata_q : '0;
        ma     = (state == IDLE) ? '0 : addr_q;
        owner  = own_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: single-access vector table plus multi-cycle sequences.
module tb_vram_arbiter;

    logic        clk, nreset;
    logic        cpu_req, cpu_wr, ppu_req, dma_req, ppu_busy;
    logic [12:0] cpu_addr, ppu_addr, dma_addr, ma;
    logic [7:0]  cpu_wdata, rdata, md_out, md_in;
    logic        cpu_ack, ppu_ack, dma_ack, md_oe, nmcs, nmoe, nmwr;
    logic [1:0]  owner;

    int n_vec = 0;
    int n_err = 0;

    vram_arbiter dut (
        .clk(clk), .nreset(nreset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .dma_req(dma_req), .dma_addr(dma_addr),
        .ppu_busy(ppu_busy), .cpu_ack(cpu_ack), .ppu_ack(ppu_ack), .dma_ack(dma_ack),
        .rdata(rdata), .ma(ma), .md_out(md_out), .md_oe(md_oe), .md_in(md_in),
        .nmcs(nmcs), .nmoe(nmoe), .nmwr(nmwr), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  who;     // 1=CPU 2=PPU 3=DMA
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  md;
        logic [7:0]  exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_all();
        cpu_req = 1'b0; ppu_req = 1'b0; dma_req = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [2:0] exp_acks;
        exp_acks = (v.who == 2'd1) ? 3'b100 : (v.who == 2'd2) ? 3'b010 : 3'b001;
        md_in = v.md;
        case (v.who)
            2'd1: begin cpu_req = 1'b1; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata; end
            2'd2: begin ppu_req = 1'b1; ppu_addr = v.addr; end
            default: begin dma_req = 1'b1; dma_addr = v.addr; end
        endcase
        step();
        chk("addr_owner", owner, v.who);
        chk("addr_strobes", {nmcs, nmoe, nmwr}, 3'b011);
        chk("addr_ma", ma, v.addr);
        step();
        chk("data_strobes", {nmcs, nmoe, nmwr, md_oe}, {1'b0, v.wr, !v.wr, v.wr});
        chk("data_md_out", md_out, v.wr ? v.wdata : 8'h00);
        step();
        chk("ack", {cpu_ack, ppu_ack, dma_ack}, exp_acks);
        chk("rdata", rdata, v.exp_rd);
        chk("ack_idle", {owner, nmcs}, 3'b001);
        drop_all();
        step();
        chk("ack_pulse", {cpu_ack, ppu_ack, dma_ack}, 3'b000);
    endtask

    vec_t vecs[7];
    int t_ppu, t_dma, t_cpu;

    initial begin
        vecs[0] = '{2'd1, 1'b0, 13'h0123, 8'h00, 8'h5A, 8'h5A};
        vecs[1] = '{2'd1, 1'b1, 13'h1FFF, 8'hC3, 8'h00, 8'h5A};
        vecs[2] = '{2'd2, 1'b0, 13'h0ABC, 8'h00, 8'h3C, 8'h3C};
        vecs[3] = '{2'd3, 1'b0, 13'h1000, 8'h00, 8'h96, 8'h96};
        vecs[4] = '{2'd1, 1'b1, 13'h0000, 8'hA5, 8'h11, 8'h96};
        vecs[5] = '{2'd1, 1'b0, 13'h1FFF, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{2'd2, 1'b0, 13'h1FFF, 8'h00, 8'hFF, 8'hFF};

        nreset = 1'b0; ppu_busy = 1'b0; md_in = 8'h00;
        cpu_addr = '0; ppu_addr = '0; dma_addr = '0; cpu_wdata = '0;
        drop_all();
        repeat (2) step();
        chk("rst_strobes", {nmcs, nmoe, nmwr, md_oe}, 4'b1110);
        chk("rst_bus", {ma, md_out}, 21'h0);
        chk("rst_rdata", rdata, 8'hFF);
        chk("rst_acks_owner", {cpu_ack, ppu_ack, dma_ack, owner}, 5'b0);
        nreset = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // All three at once: PPU, DMA, CPU in turn.
        t_ppu = 0; t_dma = 0; t_cpu = 0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0001;
        ppu_req = 1'b1; ppu_addr = 13'h0002;
        dma_req = 1'b1; dma_addr = 13'h0003;
        md_in = 8'h42;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            step();
            if (cyc == 1) chk("sim_own1", owner, 2'd2);
            if (cyc == 4) chk("sim_own4", owner, 2'd3);
            if (cyc == 7) chk("sim_own7", owner, 2'd1);
            if (ppu_ack) begin t_ppu = cyc; ppu_req = 1'b0; end
            if (dma_ack) begin t_dma = cyc; dma_req = 1'b0; end
            if (cpu_ack) begin t_cpu = cyc; cpu_req = 1'b0; end
        end
        chk("sim_ppu_ack_cyc", t_ppu, 3);
        chk("sim_dma_ack_cyc", t_dma, 6);
        chk("sim_cpu_ack_cyc", t_cpu, 9);
        drop_all();
        step();

        // Request dropped during ADDR still completes.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0777; md_in = 8'h0E;
        step();
        cpu_req = 1'b0;
        chk("drop_owner", owner, 2'd1);
        step();
        step();
        chk("drop_ack", cpu_ack, 1'b1);
        chk("drop_rdata", rdata, 8'h0E);
        step();

        // Reset in the DATA cycle of a DMA read.
        dma_req = 1'b1; dma_addr = 13'h0456; md_in = 8'h6B;
        step();
        step();
        chk("rst_mid_data", {nmcs, nmoe}, 2'b00);
        #2 nreset = 1'b0;
        #1;
        chk("rst_mid_strobes", {nmcs, nmoe, nmwr, owner}, 5'b11100);
        chk("rst_mid_ack", dma_ack, 1'b0);
        step();
        chk("rst_mid_noack", dma_ack, 1'b0);
        nreset = 1'b1;
        step();
        chk("rst_restart_owner", owner, 2'd3);
        chk("rst_restart_ma", ma, 13'h0456);
        chk("rst_restart_cs", {nmcs, nmoe}, 2'b01);
        step();
        step();
        chk("rst_restart_ack", dma_ack, 1'b1);
        chk("rst_restart_rdata", rdata, 8'h6B);
        drop_all();
        step();

        // CPU read while the PPU holds the bus in pixel transfer.
        ppu_busy = 1'b1; md_in = 8'h77;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 13'h0888;
        t_cpu = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step();
            if (cpu_ack && t_cpu == 0) begin
                t_cpu = cyc;
                cpu_req = 1'b0;
`ifdef VRAM_ARBITER_CPU_LOCK_EN
                chk("lock_rdata", rdata, 8'hFF);
                chk("lock_nmcs", nmcs, 1'b1);
`else
                chk("nolock_rdata", rdata, 8'h77);
`endif
            end
        end
`ifdef VRAM_ARBITER_CPU_LOCK_EN
        chk("lock_ack_cyc", t_cpu, 1);
`else
        chk("nolock_ack_cyc", t_cpu, 3);
`endif
        ppu_busy = 1'b0;
        drop_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
